// File: rtl/fetch_prefetch_if.sv
// Instruction-memory read channel between the prefetching fetch stage and memory.
// One outstanding read; mem_rd is held with a stable mem_addr until mem_done.
interface fetch_prefetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_done;
  logic [INSTR_W-1:0] mem_data;

  modport master (
    output mem_rd, mem_addr,
    input  mem_done, mem_data
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_done, mem_data
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue, flush redirect and interrupt entry.
// state | meaning
// IDLE  | no read outstanding; issue one when the queue has room
// REQ   | read outstanding, result will be pushed into the queue
// DRAIN | read outstanding after flush/interrupt, result is dropped
module fetch_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  in_PC_next,
  input  logic               stall,
  input  logic               INT,
  input  logic [ADDR_W-1:0]  INT_VEC,
  output logic               ACK,
  output logic [ADDR_W-1:0]  epc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  out_PC,
  output logic [ADDR_W-1:0]  out_PC_next,
  output logic               out_valid,
  fetch_prefetch_if.master   mem
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);
  localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic               ack_q;
  logic               armed_q, armed_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [INSTR_W-1:0] qi_q [DEPTH];
  logic [ADDR_W-1:0]  qp_q [DEPTH];

  logic rd_active, accept, kill, pop, push, credit;

  assign rd_active = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign accept    = INT & armed_q & ~flush;
  assign kill      = flush | accept;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & ~stall;
  assign push      = (state_q == S_REQ) & mem.mem_done & ~kill;

  assign mem.mem_rd   = rd_active;
  assign mem.mem_addr = addr_q;

  assign instr       = qi_q[head_q];
  assign out_PC      = qp_q[head_q];
  assign out_PC_next = qp_q[head_q] + INC;
  assign ACK         = ack_q;
  assign epc         = epc_q;

  // Credit is judged on the post-update occupancy so a push never meets a full queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end
    credit = (count_d < FULL);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fpc_d   = fpc_q;
    case (state_q)
      S_IDLE: begin
        if (!kill && credit) begin
          state_d = S_REQ;
          addr_d  = fpc_q;
        end
      end
      S_REQ: begin
        if (mem.mem_done) begin
          if (kill) begin
            state_d = S_IDLE;
          end else begin
            fpc_d = addr_q + INC;
            if (credit) addr_d  = addr_q + INC;
            else        state_d = S_IDLE;
          end
        end else if (kill) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem.mem_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush)       fpc_d = in_PC_next;
    else if (accept) fpc_d = INT_VEC;
  end

  always_comb begin
    epc_d   = epc_q;
    armed_d = armed_q;
    if (accept) epc_d = out_valid ? qp_q[head_q] : fpc_q;
    if (!INT)        armed_d = 1'b1;
    else if (accept) armed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= '0;
      epc_q   <= '0;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      epc_q   <= epc_d;
      ack_q   <= accept;
      armed_q <= armed_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qi_q[tail_q] <= mem.mem_data;
      qp_q[tail_q] <= addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_prefetch;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          INT = 1'b0;
  logic [AW-1:0] in_PC_next = '0;
  logic [AW-1:0] INT_VEC = '0;
  logic          ACK, out_valid;
  logic [AW-1:0] epc, out_PC, out_PC_next;
  logic [IW-1:0] instr;

  int lat  = 1;
  int mcnt = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit watch108 = 1'b0;
  int saw108   = 0;
  int acks;

  fetch_prefetch_if #(.ADDR_W(AW), .INSTR_W(IW)) mem ();

  fetch_prefetch #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_INC(4), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_PC_next(in_PC_next),
    .stall(stall), .INT(INT), .INT_VEC(INT_VEC), .ACK(ACK), .epc(epc),
    .instr(instr), .out_PC(out_PC), .out_PC_next(out_PC_next),
    .out_valid(out_valid), .mem(mem)
  );

  always #5 clk = ~clk;

  // Memory returns data equal to the address after lat cycles of mem_rd.
  assign mem.mem_done = mem.mem_rd && (mcnt == lat - 1);
  assign mem.mem_data = mem.mem_addr;
  always @(posedge clk) begin
    if (mem.mem_rd && !mem.mem_done) mcnt <= mcnt + 1;
    else                             mcnt <= 0;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkb(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of fetched entries plus one outstanding-read record.
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc, m_addr, m_epc;
  bit          m_busy, m_drop, m_ack, m_armed;

  always @(posedge clk or negedge rst_n) begin : model_step
    bit          acc, kl, pp, got, keep;
    logic [31:0] old_fpc, old_addr;
    ent_t        e;
    if (!rst_n) begin
      mq.delete();
      m_fpc   = 32'h100;
      m_addr  = '0;
      m_epc   = '0;
      m_busy  = 1'b0;
      m_drop  = 1'b0;
      m_ack   = 1'b0;
      m_armed = 1'b1;
    end else begin
      acc  = INT && m_armed && !flush;
      kl   = flush || acc;
      pp   = (mq.size() != 0) && !stall;
      got  = m_busy && mem.mem_done;
      keep = got && !m_drop && !kl;
      m_ack = acc;
      if (acc) m_epc = (mq.size() != 0) ? mq[0].pc : m_fpc;
      if (!INT)     m_armed = 1'b1;
      else if (acc) m_armed = 1'b0;
      old_fpc  = m_fpc;
      old_addr = m_addr;
      if (kl) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (keep) begin
          e.ins = old_addr;
          e.pc  = old_addr;
          mq.push_back(e);
        end
      end
      if (flush)     m_fpc = in_PC_next;
      else if (acc)  m_fpc = INT_VEC;
      else if (keep) m_fpc = old_addr + 32'd4;
      if (got) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
        if (keep && mq.size() < DEPTH) begin
          m_busy = 1'b1;
          m_addr = old_addr + 32'd4;
        end
      end else if (m_busy) begin
        if (kl) m_drop = 1'b1;
      end else if (!kl && mq.size() < DEPTH) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = old_fpc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chkb("mem_rd", mem.mem_rd, m_busy);
      if (m_busy) chk("mem_addr", mem.mem_addr, m_addr);
      chkb("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("instr", instr, mq[0].ins);
        chk("out_PC", out_PC, mq[0].pc);
        chk("out_PC_next", out_PC_next, mq[0].pc + 32'd4);
      end
      chkb("ACK", ACK, m_ack);
      chk("epc", epc, m_epc);
      if (watch108 && out_valid && out_PC == 32'h108) saw108++;
    end
  end

  task automatic nedge(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0; stall = 1'b0; INT = 1'b0;
    in_PC_next = '0; INT_VEC = '0;
    nedge(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming from RESET_PC with 1-cycle memory
    lat = 1;
    do_reset();
    chkb("rst_mem_rd", mem.mem_rd, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_ACK", ACK, 1'b0);
    chk("rst_epc", epc, 32'h0);
    nedge(1);
    chkb("s1_rd", mem.mem_rd, 1'b1);
    chk("s1_addr0", mem.mem_addr, 32'h100);
    chkb("s1_nv", out_valid, 1'b0);
    nedge(1);
    chkb("s1_valid", out_valid, 1'b1);
    chk("s1_pc0", out_PC, 32'h100);
    chk("s1_pcn0", out_PC_next, 32'h104);
    chk("s1_addr1", mem.mem_addr, 32'h104);
    nedge(1);
    chk("s1_pc1", out_PC, 32'h104);
    chk("s1_addr2", mem.mem_addr, 32'h108);

    // Stall fills exactly DEPTH entries, then drains in order
    do_reset();
    stall = 1'b1;
    nedge(5);
    chkb("s2_full_rd", mem.mem_rd, 1'b0);
    chk("s2_head", out_PC, 32'h100);
    nedge(2);
    chkb("s2_still_idle", mem.mem_rd, 1'b0);
    stall = 1'b0;
    nedge(1);
    chk("s2_pop1", out_PC, 32'h104);
    chk("s2_resume", mem.mem_addr, 32'h110);
    nedge(3);
    chk("s2_pop4", out_PC, 32'h110);

    // Flush while a 3-cycle read to 0x108 is outstanding
    do_reset();
    lat = 3;
    watch108 = 1'b1;
    nedge(7);
    chk("s3_addr108", mem.mem_addr, 32'h108);
    flush = 1'b1; in_PC_next = 32'h400;
    nedge(1);
    flush = 1'b0;
    chkb("s3_drain_rd", mem.mem_rd, 1'b1);
    chk("s3_drain_addr", mem.mem_addr, 32'h108);
    chkb("s3_cleared", out_valid, 1'b0);
    nedge(1);
    chk("s3_hold_addr", mem.mem_addr, 32'h108);
    nedge(1);
    chkb("s3_idle", mem.mem_rd, 1'b0);
    nedge(1);
    chk("s3_redirect", mem.mem_addr, 32'h400);
    nedge(3);
    chk("s3_first", out_PC, 32'h400);
    watch108 = 1'b0;
    chk("s3_no108", saw108, 0);

    // Interrupt accept with head at 0x204
    do_reset();
    lat = 1;
    stall = 1'b1; flush = 1'b1; in_PC_next = 32'h200; INT_VEC = 32'h80;
    nedge(1);
    flush = 1'b0;
    nedge(5);
    chk("s4_head200", out_PC, 32'h200);
    stall = 1'b0;
    nedge(1);
    stall = 1'b1;
    nedge(1);
    chk("s4_head204", out_PC, 32'h204);
    chkb("s4_full", mem.mem_rd, 1'b0);
    INT = 1'b1;
    nedge(1);
    chkb("s4_ack", ACK, 1'b1);
    chk("s4_epc", epc, 32'h204);
    chkb("s4_cleared", out_valid, 1'b0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("s4_vec", mem.mem_addr, 32'h80);
      if (ACK) acks++;
    end
    chk("s4_no_reack", acks, 0);
    INT = 1'b0;
    nedge(1);
    INT = 1'b1;
    nedge(1);
    chkb("s4_reack", ACK, 1'b1);

    // Interrupt coinciding with flush is deferred one cycle
    INT = 1'b0;
    nedge(1);
    INT = 1'b1; flush = 1'b1; in_PC_next = 32'h300;
    nedge(1);
    chkb("s5_no_ack", ACK, 1'b0);
    flush = 1'b0;
    nedge(1);
    chkb("s5_ack", ACK, 1'b1);
    chk("s5_epc", epc, 32'h300);
    nedge(1);
    chk("s5_vec", mem.mem_addr, 32'h80);

    // PC wrap at the top of the address space
    INT = 1'b0; stall = 1'b0; flush = 1'b1; in_PC_next = 32'hFFFF_FFFC;
    nedge(1);
    flush = 1'b0;
    nedge(1);
    chk("s6_addr_top", mem.mem_addr, 32'hFFFF_FFFC);
    nedge(1);
    chk("s6_addr_wrap", mem.mem_addr, 32'h0);
    chk("s6_pc_top", out_PC, 32'hFFFF_FFFC);
    chk("s6_pcn_wrap", out_PC_next, 32'h0);

    // Asynchronous reset in the middle of a request
    #2;
    rst_n = 1'b0;
    #1;
    chkb("s7_async_rd", mem.mem_rd, 1'b0);
    chkb("s7_async_valid", out_valid, 1'b0);
    nedge(2);
    rst_n = 1'b1;
    nedge(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
